// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
// Shared types and constants for the sound scheduler.
//   SCHED_STATE : scheduler FSM states (IDLE, PLAY, GAP)
//   SOUND_SRC   : 2-bit sound source code; numeric order equals priority
//   FREQ_*      : default tone selects for the oscillator
// Pending-flag vectors use bit 0 = dir, bit 1 = good, bit 2 = bad, so bit
// index + 1 is the matching SOUND_SRC code.
// ---------------------------------------------------------------------------
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } SCHED_STATE;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_DIR  = 2'b01,
        SRC_GOOD = 2'b10,
        SRC_BAD  = 2'b11
    } SOUND_SRC;

    localparam logic [8:0] FREQ_A  = 9'd440;
    localparam logic [8:0] FREQ_DS = 9'd311;
    localparam logic [8:0] FREQ_C  = 9'd262;

    // Highest-priority source with its pending flag set (bad > good > dir).
    function automatic SOUND_SRC highest_src(input logic [2:0] pend);
        if (pend[2]) return SRC_BAD;
        if (pend[1]) return SRC_GOOD;
        if (pend[0]) return SRC_DIR;
        return SRC_NONE;
    endfunction

    // Pending-flag bit belonging to a source.
    function automatic logic [2:0] src_mask(input SOUND_SRC s);
        case (s)
            SRC_DIR:  return 3'b001;
            SRC_GOOD: return 3'b010;
            SRC_BAD:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
// Loadable down-counter shared by the note and gap phases. Counts down one
// per clock and parks at zero (no wrap). load takes priority over counting.
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   load        : load load_value on the next edge
//   load_value  : value to load
//   zero        : count is currently zero
// ---------------------------------------------------------------------------
module tick_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sound_scheduler.sv
// ---------------------------------------------------------------------------
// sound_scheduler
// Queues one-cycle sound requests as sticky pending flags and plays them one
// at a time by priority (bad > good > dir): each note plays NOTE_TICKS
// cycles, then GAP_TICKS silent cycles. With PREEMPT set, a strictly
// higher-priority pending request replaces the note that is playing.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : sound mode on; low forces IDLE and clears all flags
//   good_req     : good-collision request pulse
//   bad_req      : bad-collision request pulse
//   dir_req      : direction-change request pulse
//   freq         : oscillator tone select, 0 when silent
//   play         : oscillator play-enable
//   busy         : high in PLAY or GAP
//   active_src   : source of the sounding note (00 none, 01 dir, 10 good, 11 bad)
//   dropped      : pulse when a request hit an already-pending flag
// ---------------------------------------------------------------------------
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int         NOTE_TICKS = 20,
    parameter int         GAP_TICKS  = 5,
    parameter logic [8:0] FREQ_GOOD  = FREQ_A,
    parameter logic [8:0] FREQ_BAD   = FREQ_DS,
    parameter logic [8:0] FREQ_DIR   = FREQ_C,
    parameter bit         PREEMPT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       good_req,
    input  logic       bad_req,
    input  logic       dir_req,
    output logic [8:0] freq,
    output logic       play,
    output logic       busy,
    output logic [1:0] active_src,
    output logic       dropped
);

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : CW'(0);

    SCHED_STATE    state;
    SOUND_SRC      cur_src;
    SOUND_SRC      top_src;
    logic [2:0]    pending;
    logic [2:0]    req;
    logic [2:0]    clr;
    logic          grant;
    logic          zero;
    logic          load;
    logic [CW-1:0] load_value;

    function automatic logic [8:0] tone(input SOUND_SRC s);
        case (s)
            SRC_BAD:  return FREQ_BAD;
            SRC_GOOD: return FREQ_GOOD;
            SRC_DIR:  return FREQ_DIR;
            default:  return 9'd0;
        endcase
    endfunction

    assign req        = {bad_req, good_req, dir_req};
    assign top_src    = highest_src(pending);
    assign active_src = cur_src;

    // A note starts on this edge: from IDLE with anything pending, or as a
    // preemption while playing. cur_src is SRC_NONE in IDLE, so a single
    // strict priority compare covers both cases.
    always_comb begin
        grant = 1'b0;
        if (enable && (state == IDLE || (state == PLAY && PREEMPT))) begin
            grant = (top_src > cur_src);
        end
        clr = grant ? src_mask(top_src) : 3'b000;
    end

    // Timer reload on every state entry (and on preemption, which re-enters PLAY).
    always_comb begin
        load       = 1'b0;
        load_value = '0;
        if (!enable) begin
            load = 1'b1;
        end else if (grant) begin
            load       = 1'b1;
            load_value = NOTE_LOAD;
        end else if (state == PLAY && zero) begin
            load       = 1'b1;
            load_value = GAP_LOAD;
        end else if (state == GAP && zero) begin
            load = 1'b1;
        end
    end

    tick_timer #(
        .WIDTH(CW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_value(load_value),
        .zero      (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            cur_src <= SRC_NONE;
            freq    <= '0;
            play    <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else if (!enable) begin
            state   <= IDLE;
            pending <= '0;
            cur_src <= SRC_NONE;
            freq    <= '0;
            play    <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            // A set beats a grant-clear on the same flag; only a set on a
            // flag that stays pending counts as coalesced.
            dropped <= |(req & pending & ~clr);
            pending <= (pending & ~clr) | req;
            if (grant) begin
                state   <= PLAY;
                cur_src <= top_src;
                freq    <= tone(top_src);
                play    <= 1'b1;
                busy    <= 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        if (zero) begin
                            cur_src <= SRC_NONE;
                            freq    <= '0;
                            play    <= 1'b0;
                            if (GAP_TICKS == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        if (zero) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sound_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sound_scheduler
// Directed scenarios followed by randomized traffic. A reference model that
// tracks pending requests and remaining play/gap cycles predicts the outputs
// after every clock edge; predictions are queued and a separate monitor
// compares them with the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_sound_scheduler;

    localparam int NOTE = 20;
    localparam int GAP  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       good_req = 1'b0;
    logic       bad_req = 1'b0;
    logic       dir_req = 1'b0;
    logic [8:0] freq;
    logic       play;
    logic       busy;
    logic [1:0] active_src;
    logic       dropped;

    sound_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .good_req  (good_req),
        .bad_req   (bad_req),
        .dir_req   (dir_req),
        .freq      (freq),
        .play      (play),
        .busy      (busy),
        .active_src(active_src),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] freq;
        logic       play;
        logic       busy;
        logic [1:0] src;
        logic       dropped;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: source codes 1=dir, 2=good, 3=bad; larger wins.
    bit m_pend[4];
    int m_src;
    int m_play_left;
    int m_gap_left;
    bit m_drop;

    function automatic logic [8:0] tone_of(input int s);
        case (s)
            3:       return 9'd311;
            2:       return 9'd440;
            1:       return 9'd262;
            default: return 9'd0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) m_pend[s] = 1'b0;
        m_src       = 0;
        m_play_left = 0;
        m_gap_left  = 0;
        m_drop      = 1'b0;
    endfunction

    function automatic void model_step(input bit en, input bit rg, input bit rb, input bit rd);
        bit req[4];
        int best;
        int granted;
        req[0] = 1'b0;
        req[1] = rd;
        req[2] = rg;
        req[3] = rb;
        m_drop = 1'b0;
        if (!en) begin
            model_reset();
            return;
        end
        best = 0;
        for (int s = 1; s <= 3; s++) if (m_pend[s]) best = s;
        granted = 0;
        if (m_play_left == 0 && m_gap_left == 0) granted = best;
        else if (m_play_left > 0 && best > m_src) granted = best;
        for (int s = 1; s <= 3; s++) begin
            if (req[s]) begin
                if (m_pend[s] && s != granted) m_drop = 1'b1;
                m_pend[s] = 1'b1;
            end else if (s == granted) begin
                m_pend[s] = 1'b0;
            end
        end
        if (granted != 0) begin
            m_src       = granted;
            m_play_left = NOTE;
            m_gap_left  = 0;
        end else if (m_play_left > 0) begin
            m_play_left--;
            if (m_play_left == 0) begin
                m_src      = 0;
                m_gap_left = GAP;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.play    = (m_play_left > 0);
        o.freq    = o.play ? tone_of(m_src) : 9'd0;
        o.busy    = (m_play_left > 0) || (m_gap_left > 0);
        o.src     = 2'(m_src);
        o.dropped = m_drop;
        return o;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict at the rising edge.
    task automatic cycle(input bit en, input bit g, input bit b, input bit d);
        @(negedge clk);
        enable   = en;
        good_req = g;
        bad_req  = b;
        dir_req  = d;
        @(posedge clk);
        model_step(en, g, b, d);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_silent(input string name);
        checks++;
        if (play !== 1'b0 || freq !== 9'd0 || busy !== 1'b0 || active_src !== 2'b00 || dropped !== 1'b0) begin
            errors++;
            $display("FAIL %s: got freq=%0d play=%b busy=%b src=%b dropped=%b, want all zero",
                     name, freq, play, busy, active_src, dropped);
        end
    endtask

    // Asynchronous reset between clock edges, while a note may be playing.
    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        check_silent("async_reset");
        exp_q.delete();
        model_reset();
        enable   = 1'b1;
        good_req = 1'b0;
        bad_req  = 1'b0;
        dir_req  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare every predicted cycle against the DUT.
    always @(negedge clk) begin
        out_t e;
        out_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {freq, play, busy, active_src, dropped};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got freq=%0d play=%b busy=%b src=%b dropped=%b, want freq=%0d play=%b busy=%b src=%b dropped=%b",
                         $time, a.freq, a.play, a.busy, a.src, a.dropped,
                         e.freq, e.play, e.busy, e.src, e.dropped);
            end
        end
    end

    initial begin
        bit en_r;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_silent("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;

        // Single good request: 20 cycles of 440, 5-cycle gap, then idle.
        idle(9);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(30);

        // Good and bad together: bad first, gap, then good.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        idle(60);

        // Dir note preempted by bad five cycles in; dir not replayed.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(40);

        // Two dir requests during a bad note: second one coalesces.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(70);

        // Disable mid-note; requests while disabled are ignored.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(6);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle(30);

        // Reset during a bad note with good pending; nothing plays afterwards.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        reset_mid();
        idle(30);

        // Randomized traffic: sparse, then dense to exercise coalescing.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            cycle(en_r, $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0);
        end
        idle(40);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked predictions, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
Sequences the game's sound datapath: accepts one-cycle sound-event requests (good collision, bad collision, direction change), queues them as pending flags, and grants them one at a time by priority. Drives the oscillator's frequency select and play-enable for a fixed note length, followed by an optional silent gap. Sits between the edge-detected game events and the oscillator / DAC counter chain, and replaces the direct event-to-tone path.

Parameters:
NOTE_TICKS, 20, clock cycles a note plays (0.2 s at 100 Hz); must be >= 1
GAP_TICKS, 5, silent cycles after each completed note; 0 = no gap
FREQ_GOOD, 9'd440, tone for good collision (A)
FREQ_BAD, 9'd311, tone for bad collision (D#)
FREQ_DIR, 9'd262, tone for direction change (C)
PREEMPT, 1, 1 = a strictly higher-priority pending request aborts the current note

Ports:
clk  in  1  system clock (hz100)
rst  in  1  asynchronous, active-high reset
enable  in  1  sound mode ON (level)
good_req  in  1  good-collision request, 1-cycle pulse
bad_req  in  1  bad-collision request, 1-cycle pulse
dir_req  in  1  direction-change request, 1-cycle pulse
freq  out  9  tone select to oscillator; 0 when silent
play  out  1  oscillator play-enable
busy  out  1  high in PLAY or GAP
active_src  out  2  00 none, 01 dir, 10 good, 11 bad
dropped  out  1  1-cycle pulse: a request coalesced into an already-pending one

Behaviour:
- Reset (async, rst=1): state IDLE; pending flags, counter, freq, play, busy, dropped all 0; active_src=00.
- All outputs are registered.
- Pending: one sticky flag per source. A request sets its flag at the sampling edge. If the flag is already set (and not being cleared on that edge), dropped=1 for the next cycle and the flags are unchanged. If a set and a grant-clear hit the same flag on the same edge, the set wins and dropped stays 0.
- Priority: bad > good > dir.
- IDLE:
  - If enable=1 and any flag is set: grant the highest-priority flag, clear it, load freq/active_src, counter=NOTE_TICKS-1, go to PLAY.
  - Latency: request sampled at edge n -> play=1 after edge n+1.
- PLAY:
  - play=1, busy=1; freq and active_src held.
  - The counter decrements each cycle. At 0: go to GAP (counter=GAP_TICKS-1, play=0, freq=0, active_src=00). If GAP_TICKS=0, go straight to IDLE instead.
  - play is high for exactly NOTE_TICKS cycles.
- Preemption (PREEMPT=1): in PLAY, if a flag of strictly higher priority than active_src is set, the next edge grants it directly (no gap). This clears that flag and reloads the counter to NOTE_TICKS-1. The aborted note is discarded and not re-queued. An equal or lower priority request only sets its flag.
- GAP:
  - play=0, freq=0, busy=1.
  - The counter decrements each cycle. At 0: go to IDLE. The next grant happens from IDLE on the following edge.
  - Requests still set flags during GAP.
- enable low: from any state, the next edge forces IDLE and clears all flags; outputs go silent/idle. While enable=0, requests are ignored and dropped stays 0.
- Counter width: $clog2(max(NOTE_TICKS, GAP_TICKS)+1). Down-count only, no wrap. The counter is reloaded on every state entry.
- Simultaneous requests of several sources on one edge: all flags set; they are served in priority order, each followed by its gap.
- Reset mid-note: play drops to 0 immediately (async); all pending requests are lost.

Decomposition:
- Shared package sound_pkg:
  - state enum SCHED_STATE {IDLE, PLAY, GAP};
  - source enum SOUND_SRC {SRC_NONE, SRC_DIR, SRC_GOOD, SRC_BAD} (2-bit, encoding as above);
  - frequency constants FREQ_A=440, FREQ_DS=311, FREQ_C=262, which are the parameter defaults.
- One sub-module is natural: tick_timer.
  - Loadable down-counter with load, load_value, and a zero flag.
  - Used for both the note timer and the gap timer.

Test Plan:
- Reset, enable=1, good_req pulse at cycle 10 -> play=1, freq=440, active_src=10 for cycles 12..31 (20 cycles); freq=0, busy=1 for 32..36; busy=0 at 37.
- good_req and bad_req in the same cycle -> 311 plays 20 cycles, then a 5-cycle gap, then 440 plays 20 cycles; no dropped pulse.
- dir note in progress (cycle 5 of 20), bad_req pulse -> next cycle freq=311 with a fresh 20-cycle note, no gap; dir is not replayed afterwards.
- During a bad note, dir_req twice, 3 cycles apart -> second pulse gives dropped=1 for one cycle; exactly one 262 note plays after the bad note and its gap.
- Mid-note enable=0 -> next cycle play=0, freq=0, busy=0, flags cleared; a request while enable=0 gives no response; re-enabling produces no stale note.
- Assert rst during PLAY with a pending flag set -> play=0 at once; after release, no note plays without a new request. Repeat with GAP_TICKS=0 -> the second queued note starts the cycle right after the first note ends.
